fir_cfg_sequencer: RTL



---
 rtl/fir_cfg_sequencer_if.sv | 41 ++++
 rtl/fir_cfg_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fir_cfg_sequencer_if.sv
// fir_cfg_sequencer_if: host staging port, FIR coefficient/shift handshakes and status, seen from the sequencer.
interface fir_cfg_sequencer_if #(
  parameter int coef_width = 24,
  parameter int coef_count = 16,
  parameter int max_shift = 32
);
  localparam int coef_id_w = $clog2(coef_count);
  localparam int max_shift_w = $clog2(max_shift);
  logic host_wr_i;
  logic [coef_id_w-1:0] host_addr_i;
  logic [coef_width-1:0] host_data_i;
  logic host_shift_wr_i;
  logic [max_shift_w-1:0] host_shift_i;
  logic commit_i;
  logic busy_o;
  logic done_o;
  logic err_o;
  logic [coef_id_w-1:0] fir_addr_o;
  logic [coef_width-1:0] fir_coef_o;
  logic fir_coef_ready_o;
  logic fir_coef_done_i;
  logic [coef_width-1:0] fir_coef_r_i;
  logic fir_shift_ready_o;
  logic [max_shift_w-1:0] fir_shift_o;
  logic fir_shift_done_i;
  logic fir_flush_o;
  logic conv_done_i;
  logic out_valid_o;
  modport master (
    input host_wr_i, host_addr_i, host_data_i, host_shift_wr_i, host_shift_i, commit_i,
    input fir_coef_done_i, fir_coef_r_i, fir_shift_done_i, conv_done_i,
    output busy_o, done_o, err_o, fir_addr_o, fir_coef_o, fir_coef_ready_o,
    output fir_shift_ready_o, fir_shift_o, fir_flush_o, out_valid_o
  );
  modport slave (
    output host_wr_i, host_addr_i, host_data_i, host_shift_wr_i, host_shift_i, commit_i,
    output fir_coef_done_i, fir_coef_r_i, fir_shift_done_i, conv_done_i,
    input busy_o, done_o, err_o, fir_addr_o, fir_coef_o, fir_coef_ready_o,
    input fir_shift_ready_o, fir_shift_o, fir_flush_o, out_valid_o
  );
endinterface

// File: rtl/fir_cfg_sequencer.sv
// fir_cfg_sequencer: stages FIR coefficients/shift, replays them with readback verify,
// then flushes and discards settle_samples conversions before raising out_valid.
module fir_cfg_sequencer #(
  parameter int coef_width = 24,
  parameter int coef_count = 16,
  parameter int max_shift = 32,
  parameter int settle_samples = 20,
  parameter int timeout_cycles = 15
) (
  input logic clk,
  input logic rst,
  fir_cfg_sequencer_if.master bus
);
  localparam int iw = $clog2(coef_count);
  localparam int shw = $clog2(max_shift);
  localparam int tw = $clog2(timeout_cycles + 1);
  localparam int sw = $clog2(settle_samples + 1);
  localparam logic [iw-1:0] ilast = iw'(coef_count - 1);
  localparam logic [tw-1:0] tlast = tw'(timeout_cycles - 1);
  localparam logic [sw-1:0] slast = sw'(settle_samples - 1);
  typedef enum logic [3:0] {IDLE, WR_COEF, WAIT_ACK, VERIFY, WR_SHIFT, WAIT_SHIFT, FLUSH, SETTLE, ERROR} state_t;
  state_t state_q, state_d;
  logic [coef_width-1:0] stage_q [coef_count];
  logic [shw-1:0] shift_q;
  logic [iw-1:0] idx_q, idx_d;
  logic [tw-1:0] wcnt_q, wcnt_d;
  logic [sw-1:0] scnt_q, scnt_d;
  logic conv_q, err_q, err_d, ov_q, ov_d, done_q, done_d, rise;
  // Reset contents mirror the filter's own pass-through reset state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < coef_count; i++) stage_q[i] <= coef_width'(i == 0);
      shift_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.host_wr_i) stage_q[bus.host_addr_i] <= bus.host_data_i;
      if (bus.host_shift_wr_i) shift_q <= bus.host_shift_i;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wcnt_q <= '0;
      scnt_q <= '0;
      conv_q <= 1'b0;
      err_q <= 1'b0;
      ov_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wcnt_q <= wcnt_d;
      scnt_q <= scnt_d;
      conv_q <= bus.conv_done_i;
      err_q <= err_d;
      ov_q <= ov_d;
      done_q <= done_d;
    end
  // conv_q tracks the level every cycle, so a level already high on entering SETTLE is not an edge.
  assign rise = bus.conv_done_i & ~conv_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wcnt_d = wcnt_q;
    scnt_d = scnt_q;
    err_d = err_q;
    ov_d = ov_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.commit_i) begin
        state_d = WR_COEF;
        idx_d = '0;
        err_d = 1'b0;
        ov_d = 1'b0;
      end
      WR_COEF: begin
        state_d = WAIT_ACK;
        wcnt_d = '0;
      end
      WAIT_ACK: begin
        wcnt_d = wcnt_q + 1'b1;
        state_d = bus.fir_coef_done_i ? VERIFY : wcnt_q == tlast ? ERROR : WAIT_ACK;
      end
      VERIFY: begin
        state_d = bus.fir_coef_r_i != stage_q[idx_q] ? ERROR : idx_q == ilast ? WR_SHIFT : WR_COEF;
        if (state_d == WR_COEF) idx_d = idx_q + 1'b1;
      end
      WR_SHIFT: begin
        state_d = WAIT_SHIFT;
        wcnt_d = '0;
      end
      WAIT_SHIFT: begin
        wcnt_d = wcnt_q + 1'b1;
        state_d = bus.fir_shift_done_i ? FLUSH : wcnt_q == tlast ? ERROR : WAIT_SHIFT;
      end
      FLUSH: begin
        state_d = SETTLE;
        scnt_d = '0;
      end
      SETTLE: if (rise) begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == slast) begin
          state_d = IDLE;
          done_d = 1'b1;
          ov_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ERROR) err_d = 1'b1;
  end
  assign bus.busy_o = state_q != IDLE;
  assign bus.done_o = done_q;
  assign bus.err_o = err_q;
  assign bus.out_valid_o = ov_q;
  assign bus.fir_addr_o = idx_q;
  assign bus.fir_coef_ready_o = state_q == WR_COEF;
  assign bus.fir_coef_o = state_q == WR_COEF ? stage_q[idx_q] : '0;
  assign bus.fir_shift_ready_o = state_q == WR_SHIFT;
  assign bus.fir_shift_o = state_q == WR_SHIFT ? shift_q : '0;
  assign bus.fir_flush_o = state_q == FLUSH;
endmodule
